// File: rtl/wb_write_buffer_pkg.sv
// -----------------------------------------------------------------------------
// lc3b_types : shared types for the L2-side Wishbone write buffer.
//   - line address, line data and byte-select typedefs
//   - wb_buf_entry_t : one buffered line write {valid, adr, sel, data}
//   - wb_state_t     : control FSM encoding of wb_write_buffer
//   - merge_line()   : byte-granular merge of a new line into an old one
// -----------------------------------------------------------------------------
package lc3b_types;

   typedef logic [11:0]  lc3b_line_adr;
   typedef logic [127:0] lc3b_line;
   typedef logic [15:0]  lc3b_line_sel;

   typedef struct packed {
      logic         valid;
      lc3b_line_adr adr;
      lc3b_line_sel sel;
      lc3b_line     data;
   } wb_buf_entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_FWD  = 2'd1,
      DRAIN   = 2'd2,
      RD_RESP = 2'd3
   } wb_state_t;

   localparam lc3b_line_sel SEL_ALL = 16'hFFFF;

   // Bytes whose select bit is set come from new_data, the rest keep old_data.
   function automatic lc3b_line merge_line(input lc3b_line     old_data,
                                           input lc3b_line     new_data,
                                           input lc3b_line_sel new_sel);
      lc3b_line result;
      result = old_data;
      for (int i = 0; i < 16; i++) begin
         if (new_sel[i]) begin
            result[i*8 +: 8] = new_data[i*8 +: 8];
         end else begin
            result[i*8 +: 8] = old_data[i*8 +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_write_buffer_array.sv
// -----------------------------------------------------------------------------
// wb_buffer_array : in-order storage for posted line writes.
//   clk, rst          clock, asynchronous active-high reset
//   push              append {wr_adr, wr_sel, wr_data} at the tail
//   merge             byte-merge wr_sel/wr_data into the entry matching lookup_adr
//   pop               retire the head entry
//   lookup_adr        address compared in parallel against all valid entries
//   head_adr/sel/data contents of the oldest entry
//   full, empty, hit  occupancy flags and address-match result
// -----------------------------------------------------------------------------
module wb_buffer_array
   import lc3b_types::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         merge,
   input  logic         pop,
   input  lc3b_line_adr wr_adr,
   input  lc3b_line_sel wr_sel,
   input  lc3b_line     wr_data,
   input  lc3b_line_adr lookup_adr,
   output lc3b_line_adr head_adr,
   output lc3b_line_sel head_sel,
   output lc3b_line     head_data,
   output logic         full,
   output logic         empty,
   output logic         hit
);

   wb_buf_entry_t    ent_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic [DEPTH-1:0] match_s;
   logic [PTR_W-1:0] hit_idx_s;

   // Parallel address compare; lowest matching index is the merge target
   always_comb begin
      match_s   = '0;
      hit_idx_s = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_s[i] = ent_r[i].valid & (ent_r[i].adr == lookup_adr);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (match_s[i]) begin
            hit_idx_s = PTR_W'(i);
         end else begin
            hit_idx_s = hit_idx_s;
         end
      end
   end

   // Entry storage, FIFO pointers and occupancy count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_r[i] <= '0;
         end
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (push) begin
            ent_r[tail_r] <= '{valid: 1'b1, adr: wr_adr, sel: wr_sel, data: wr_data};
            tail_r        <= tail_r + PTR_W'(1);
         end else if (merge) begin
            ent_r[hit_idx_s].sel  <= ent_r[hit_idx_s].sel | wr_sel;
            ent_r[hit_idx_s].data <= merge_line(ent_r[hit_idx_s].data, wr_data, wr_sel);
         end
         if (pop) begin
            ent_r[head_r].valid <= 1'b0;
            head_r              <= head_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign hit       = |match_s;
   assign head_adr  = ent_r[head_r].adr;
   assign head_sel  = ent_r[head_r].sel;
   assign head_data = ent_r[head_r].data;
   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == CNT_W'(0));

endmodule

// File: rtl/wb_write_buffer.sv
// -----------------------------------------------------------------------------
// wb_write_buffer : posted-write buffer between the L1 interconnect's L2-side
// Wishbone master (u_*) and the downstream L2 / memory slave (d_*).
//   Writes are acked one cycle after acceptance and queued in order; queued
//   writes drain when upstream is idle, the buffer is full, or a read hits a
//   buffered address. Read misses are forwarded straight downstream.
//   clk, rst                 clock, asynchronous active-high reset
//   u_cyc/stb/we/sel/adr     upstream request; u_dat_m write data
//   u_dat_s, u_ack, u_rty    upstream response (u_rty is always 0)
//   d_cyc/stb/we/sel/adr     downstream request; d_dat_m write data
//   d_dat_s, d_ack, d_rty    downstream response
// Optional feature: define WB_WRITE_BUFFER_COALESCE_EN to merge writes whose
// address matches a buffered entry instead of enqueueing a new entry.
// -----------------------------------------------------------------------------
module wb_write_buffer
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          u_cyc,
   input  logic          u_stb,
   input  logic          u_we,
   input  logic [15:0]   u_sel,
   input  logic [11:0]   u_adr,
   input  logic [127:0]  u_dat_m,
   output logic [127:0]  u_dat_s,
   output logic          u_ack,
   output logic          u_rty,
   output logic          d_cyc,
   output logic          d_stb,
   output logic          d_we,
   output logic [15:0]   d_sel,
   output logic [11:0]   d_adr,
   output logic [127:0]  d_dat_m,
   input  logic [127:0]  d_dat_s,
   input  logic          d_ack,
   input  logic          d_rty
);

`ifdef WB_WRITE_BUFFER_COALESCE_EN
   localparam logic COALESCE = 1'b1;
`else
   localparam logic COALESCE = 1'b0;
`endif

   wb_state_t    state_r;
   logic         u_ack_r;
   lc3b_line     u_dat_s_r;
   logic         d_cyc_r;
   logic         d_stb_r;
   logic         d_we_r;
   lc3b_line_sel d_sel_r;
   lc3b_line_adr d_adr_r;
   lc3b_line     d_dat_m_r;

   lc3b_line_adr head_adr_s;
   lc3b_line_sel head_sel_s;
   lc3b_line     head_data_s;
   logic         buf_full_s;
   logic         buf_empty_s;
   logic         buf_hit_s;

   logic req_s;
   logic up_idle_s;
   logic rd_miss_s;
   logic rd_hit_s;
   logic wr_push_s;
   logic wr_merge_s;
   logic drain_start_s;
   logic pop_s;

   // Request decode and IDLE-state priority resolution
   always_comb begin
      // ~u_ack keeps a request that is still held during its ack from re-firing
      req_s         = u_cyc & u_stb & ~u_ack_r;
      // Upstream counts as busy while it holds cyc/stb, including its ack cycle,
      // so back-to-back writes are not interrupted by opportunistic drains
      up_idle_s     = ~(u_cyc & u_stb);
      pop_s         = (state_r == DRAIN) & d_stb_r & d_ack;
      rd_miss_s     = 1'b0;
      rd_hit_s      = 1'b0;
      wr_merge_s    = 1'b0;
      wr_push_s     = 1'b0;
      drain_start_s = 1'b0;
      if (state_r == IDLE) begin
         rd_miss_s     = req_s & ~u_we & ~buf_hit_s;
         rd_hit_s      = req_s & ~u_we & buf_hit_s;
         wr_merge_s    = req_s & u_we & COALESCE & buf_hit_s;
         wr_push_s     = req_s & u_we & ~wr_merge_s & ~buf_full_s;
         drain_start_s = ~buf_empty_s &
                         (up_idle_s | (req_s & u_we & buf_full_s & ~wr_merge_s));
      end else begin
         rd_miss_s     = 1'b0;
         drain_start_s = 1'b0;
      end
   end

   wb_buffer_array #(
      .DEPTH (DEPTH)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .push       (wr_push_s),
      .merge      (wr_merge_s),
      .pop        (pop_s),
      .wr_adr     (u_adr),
      .wr_sel     (u_sel),
      .wr_data    (u_dat_m),
      .lookup_adr (u_adr),
      .head_adr   (head_adr_s),
      .head_sel   (head_sel_s),
      .head_data  (head_data_s),
      .full       (buf_full_s),
      .empty      (buf_empty_s),
      .hit        (buf_hit_s)
   );

   // Control FSM and all registered port drivers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         u_ack_r   <= 1'b0;
         u_dat_s_r <= '0;
         d_cyc_r   <= 1'b0;
         d_stb_r   <= 1'b0;
         d_we_r    <= 1'b0;
         d_sel_r   <= '0;
         d_adr_r   <= '0;
         d_dat_m_r <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               u_ack_r <= 1'b0;
               if (rd_miss_s) begin
                  state_r <= RD_FWD;
                  d_cyc_r <= 1'b1;
                  d_stb_r <= 1'b1;
                  d_we_r  <= 1'b0;
                  d_sel_r <= SEL_ALL;
                  d_adr_r <= u_adr;
               end else if (rd_hit_s | drain_start_s) begin
                  // A read hit drains the head; IDLE re-checks the hit afterwards
                  state_r   <= DRAIN;
                  d_cyc_r   <= 1'b1;
                  d_stb_r   <= 1'b1;
                  d_we_r    <= 1'b1;
                  d_sel_r   <= head_sel_s;
                  d_adr_r   <= head_adr_s;
                  d_dat_m_r <= head_data_s;
               end else if (wr_push_s | wr_merge_s) begin
                  u_ack_r <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_FWD: begin
               if (d_stb_r) begin
                  if (d_ack) begin
                     u_dat_s_r <= d_dat_s;
                     u_ack_r   <= 1'b1;
                     d_cyc_r   <= 1'b0;
                     d_stb_r   <= 1'b0;
                     state_r   <= RD_RESP;
                  end else if (d_rty) begin
                     d_stb_r <= 1'b0;
                  end else begin
                     state_r <= RD_FWD;
                  end
               end else begin
                  // One strobe-low cycle after a retry, then reissue unchanged
                  d_stb_r <= 1'b1;
               end
            end
            DRAIN: begin
               if (d_stb_r) begin
                  if (d_ack) begin
                     d_cyc_r <= 1'b0;
                     d_stb_r <= 1'b0;
                     d_we_r  <= 1'b0;
                     state_r <= IDLE;
                  end else if (d_rty) begin
                     d_stb_r <= 1'b0;
                  end else begin
                     state_r <= DRAIN;
                  end
               end else begin
                  d_stb_r <= 1'b1;
               end
            end
            RD_RESP: begin
               u_ack_r <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               u_ack_r <= 1'b0;
               d_cyc_r <= 1'b0;
               d_stb_r <= 1'b0;
               d_we_r  <= 1'b0;
            end
         endcase
      end
   end

   assign u_dat_s = u_dat_s_r;
   assign u_ack   = u_ack_r;
   assign u_rty   = 1'b0;
   assign d_cyc   = d_cyc_r;
   assign d_stb   = d_stb_r;
   assign d_we    = d_we_r;
   assign d_sel   = d_sel_r;
   assign d_adr   = d_adr_r;
   assign d_dat_m = d_dat_m_r;

endmodule

// File: tb/tb_wb_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_wb_write_buffer : scoreboard bench for wb_write_buffer (DEPTH = 4).
// Stimulus pushes expected upstream acks and downstream transactions into
// queues; negedge monitors pop and compare when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_wb_write_buffer;

   logic         clk;
   logic         rst;
   logic         u_cyc, u_stb, u_we;
   logic [15:0]  u_sel;
   logic [11:0]  u_adr;
   logic [127:0] u_dat_m;
   logic [127:0] u_dat_s;
   logic         u_ack, u_rty;
   logic         d_cyc, d_stb, d_we;
   logic [15:0]  d_sel;
   logic [11:0]  d_adr;
   logic [127:0] d_dat_m;
   logic [127:0] d_dat_s;
   logic         d_ack, d_rty;

   wb_write_buffer #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .u_cyc(u_cyc), .u_stb(u_stb), .u_we(u_we), .u_sel(u_sel), .u_adr(u_adr),
      .u_dat_m(u_dat_m), .u_dat_s(u_dat_s), .u_ack(u_ack), .u_rty(u_rty),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_adr(d_adr),
      .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack), .d_rty(d_rty)
   );

   typedef struct {
      logic         we;
      logic [11:0]  adr;
      logic [15:0]  sel;
      logic [127:0] data;
   } dn_ent_t;

   typedef struct {
      logic         rd;
      logic [127:0] data;
      int           mode;   // 0 none, 1 read ack one cycle after d_ack, 2 write ack two cycles after a drain ack
   } up_ent_t;

   dn_ent_t exp_down[$];
   up_ent_t exp_up[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;
   int lat     = 2;
   bit rty_once = 1'b0;
   int rty_seen = 0;
   int dcyc_seen = 0;
   int last_rd_ack = 0;
   int last_wr_ack = 0;
   logic prev_ack = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [15:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = s[i] ? d[i*8 +: 8] : 8'h00;
      return r;
   endfunction

   function automatic logic [127:0] rd_line(input logic [11:0] adr);
      return {8{adr, 4'hC}};
   endfunction

   // Downstream slave: ack (or one retry) after `lat` strobe cycles
   initial begin
      int wait_cnt;
      d_ack = 1'b0; d_rty = 1'b0; d_dat_s = '0; wait_cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            d_ack = 1'b0; d_rty = 1'b0; wait_cnt = 0;
         end else if (d_ack | d_rty) begin
            d_ack = 1'b0; d_rty = 1'b0; wait_cnt = 0;
         end else if (d_cyc & d_stb) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
               if (rty_once) begin
                  d_rty = 1'b1; rty_once = 1'b0;
               end else begin
                  d_ack = 1'b1; d_dat_s = rd_line(d_adr);
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Downstream monitor: transaction order/content and retry behaviour
   int      rty_phase = 0;
   dn_ent_t rty_save;
   always @(negedge clk) begin
      dn_ent_t de;
      if (!rst) begin
         if (d_cyc) dcyc_seen++;
         if (rty_phase == 1) begin
            check("rty_stb_low", {126'd0, d_cyc, d_stb}, {126'd0, 2'b10});
            rty_phase = 2;
         end else if (rty_phase == 2) begin
            check("rty_reissue_ctl", {125'd0, d_cyc, d_stb, d_we}, {125'd0, 3'b111});
            check("rty_reissue_adr", {100'd0, d_adr, d_sel}, {100'd0, rty_save.adr, rty_save.sel});
            check("rty_reissue_dat", d_dat_m, rty_save.data);
            rty_phase = 0;
         end else if (d_cyc & d_stb & d_rty) begin
            rty_save.adr = d_adr; rty_save.sel = d_sel; rty_save.data = d_dat_m;
            rty_seen++;
            rty_phase = 1;
         end
         if (d_cyc & d_stb & d_ack) begin
            if (exp_down.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL dn_unexpected: got adr %h we %b, expected no transaction", d_adr, d_we);
            end else begin
               de = exp_down.pop_front();
               check("dn_we", {127'd0, d_we}, {127'd0, de.we});
               check("dn_adr", {116'd0, d_adr}, {116'd0, de.adr});
               check("dn_sel", {112'd0, d_sel}, {112'd0, de.sel});
               if (de.we) check("dn_data", mask_bytes(d_dat_m, de.sel), mask_bytes(de.data, de.sel));
               if (d_we) last_wr_ack = cyc_cnt;
               else      last_rd_ack = cyc_cnt;
            end
         end
      end
   end

   // Upstream monitor: ack pulses, read data and ack timing
   always @(negedge clk) begin
      up_ent_t ue;
      if (!rst && u_ack) begin
         check("u_ack_pulse", {127'd0, prev_ack}, 128'd0);
         if (exp_up.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL up_unexpected: got u_ack, expected none");
         end else begin
            ue = exp_up.pop_front();
            if (ue.rd) check("u_dat_s", u_dat_s, ue.data);
            if (ue.mode == 1) check("rd_ack_lat", 128'(cyc_cnt), 128'(last_rd_ack + 1));
            if (ue.mode == 2) check("wr_after_drain", 128'(cyc_cnt), 128'(last_wr_ack + 2));
         end
      end
      prev_ack = u_ack;
   end

   task automatic up_write(input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] dat,
                           input int exp_lat, input int mode, input bit push_down);
      up_ent_t ue; dn_ent_t de; int n;
      ue.rd = 1'b0; ue.data = '0; ue.mode = mode;
      exp_up.push_back(ue);
      if (push_down) begin
         de.we = 1'b1; de.adr = adr; de.sel = sel; de.data = dat;
         exp_down.push_back(de);
      end
      u_cyc = 1'b1; u_stb = 1'b1; u_we = 1'b1; u_sel = sel; u_adr = adr; u_dat_m = dat;
      if (u_ack) begin @(posedge clk); #1; end
      n = 0;
      while (!u_ack && n < 300) begin @(posedge clk); #1; n++; end
      if (!u_ack) begin
         n_tests++; n_fail++;
         $display("FAIL wr_timeout: got no u_ack for adr %h, expected u_ack", adr);
      end else if (exp_lat > 0) begin
         check("wr_lat", 128'(n), 128'(exp_lat));
      end
   endtask

   task automatic up_read(input logic [11:0] adr, input bit push_down);
      up_ent_t ue; dn_ent_t de; int n;
      ue.rd = 1'b1; ue.data = rd_line(adr); ue.mode = 1;
      exp_up.push_back(ue);
      if (push_down) begin
         de.we = 1'b0; de.adr = adr; de.sel = 16'hFFFF; de.data = '0;
         exp_down.push_back(de);
      end
      u_cyc = 1'b1; u_stb = 1'b1; u_we = 1'b0; u_sel = 16'hFFFF; u_adr = adr;
      if (u_ack) begin @(posedge clk); #1; end
      n = 0;
      while (!u_ack && n < 300) begin @(posedge clk); #1; n++; end
      if (!u_ack) begin
         n_tests++; n_fail++;
         $display("FAIL rd_timeout: got no u_ack for adr %h, expected u_ack", adr);
      end
   endtask

   task automatic up_idle();
      u_cyc = 1'b0; u_stb = 1'b0; u_we = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_down.size() != 0 && n < 400) begin @(posedge clk); #1; n++; end
      if (exp_down.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_down.size());
         exp_down.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      dn_ent_t de;
      int n;
      rst = 1'b1;
      u_cyc = 1'b0; u_stb = 1'b0; u_we = 1'b0; u_sel = '0; u_adr = '0; u_dat_m = '0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_u_ack",   {127'd0, u_ack}, 128'd0);
      check("rst_u_rty",   {127'd0, u_rty}, 128'd0);
      check("rst_u_dat_s", u_dat_s, 128'd0);
      check("rst_d_ctl",   {125'd0, d_cyc, d_stb, d_we}, 128'd0);
      check("rst_d_sel",   {112'd0, d_sel}, 128'd0);
      check("rst_d_adr",   {116'd0, d_adr}, 128'd0);
      check("rst_d_dat_m", d_dat_m, 128'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // Single write into an empty buffer, drained once upstream idles
      lat = 2;
      up_write(12'h010, 16'hFFFF, {16{8'hA5}}, 1, 0, 1'b1);
      up_idle();
      wait_drain();

      // Five back-to-back writes: fifth stalls until the first drain completes
      lat = 3;
      for (int i = 1; i <= 5; i++) begin
         up_write(12'(i), 16'hFFFF, {8{4'hB, 12'(i)}}, (i < 5) ? 1 : 0, (i == 5) ? 2 : 0, 1'b1);
      end
      up_idle();
      wait_drain();

      // Read hit: buffered 0x020 is written downstream before the read
      lat = 2;
      up_write(12'h020, 16'hFFFF, {16{8'h3C}}, 1, 0, 1'b1);
      up_read(12'h020, 1'b1);
      up_idle();
      wait_drain();

      // Read miss: forwarded ahead of the buffered write
      up_write(12'h020, 16'h0FF0, {16{8'h5E}}, 1, 0, 1'b0);
      up_read(12'h030, 1'b1);
      de.we = 1'b1; de.adr = 12'h020; de.sel = 16'h0FF0; de.data = {16{8'h5E}};
      exp_down.push_back(de);
      up_idle();
      wait_drain();

      // Retry on the first drain attempt
      rty_once = 1'b1;
      up_write(12'h050, 16'hF00F, {4{32'hDEADBEEF}}, 1, 0, 1'b1);
      up_idle();
      wait_drain();
      check("rty_seen", 128'(rty_seen), 128'd1);

      // Same-address writes: merged with the coalescing build, in order otherwise
      up_write(12'h040, 16'h000F, {16{8'h11}}, 1, 0, 1'b0);
      up_write(12'h040, 16'h00F0, {16{8'h22}}, 1, 0, 1'b0);
`ifdef WB_WRITE_BUFFER_COALESCE_EN
      de.we = 1'b1; de.adr = 12'h040; de.sel = 16'h00FF;
      de.data = {{8{8'h11}}, {4{8'h22}}, {4{8'h11}}};
      exp_down.push_back(de);
`else
      de.we = 1'b1; de.adr = 12'h040; de.sel = 16'h000F; de.data = {16{8'h11}};
      exp_down.push_back(de);
      de.sel = 16'h00F0; de.data = {16{8'h22}};
      exp_down.push_back(de);
`endif
      up_idle();
      wait_drain();

      // Reset in the middle of a drain
      lat = 20;
      up_write(12'h060, 16'hFFFF, {16{8'h66}}, 1, 0, 1'b0);
      up_write(12'h061, 16'hFFFF, {16{8'h67}}, 1, 0, 1'b0);
      up_idle();
      n = 0;
      while (!d_cyc && n < 50) begin @(posedge clk); #1; n++; end
      check("rst_drain_started", {127'd0, d_cyc}, 128'd1);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      check("rst_async_d_cyc", {126'd0, d_cyc, d_stb}, 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      lat = 2;
      dcyc_seen = 0;
      repeat (30) @(posedge clk);
      #1;
      check("post_rst_no_drain", 128'(dcyc_seen), 128'd0);
      check("post_rst_u_ack", {127'd0, u_ack}, 128'd0);

      check("exp_up_empty", 128'(exp_up.size()), 128'd0);
      check("exp_down_empty", 128'(exp_down.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_write_buffer.md
Name: wb_write_buffer

Overview:
- Posted-write buffer directly downstream of the L1 I/D-cache interconnect's L2-side Wishbone master.
- Accepts 128-bit line reads and writes from that master. Writes are acknowledged after one cycle and queued in a small in-order buffer.
- Queued writes drain to the downstream Wishbone slave (L2 / physical memory) whenever the upstream side is idle, the buffer is full, or a read needs them out first.
- Reads that hit no buffered entry are forwarded immediately, so read-after-write ordering is preserved.

Parameters:
- DEPTH, 4, number of buffered line writes; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- u_cyc  in  1  upstream cycle
- u_stb  in  1  upstream strobe
- u_we  in  1  upstream write enable
- u_sel  in  16  upstream byte enables
- u_adr  in  12  upstream line address
- u_dat_m  in  128  upstream write data
- u_dat_s  out  128  upstream read data
- u_ack  out  1  upstream acknowledge
- u_rty  out  1  upstream retry, tied 0
- d_cyc, d_stb, d_we  out  1 each  downstream control
- d_sel  out  16  downstream byte enables
- d_adr  out  12  downstream line address
- d_dat_m  out  128  downstream write data
- d_dat_s  in  128  downstream read data
- d_ack  in  1  downstream acknowledge
- d_rty  in  1  downstream retry

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all entries invalid, count=0, FSM=IDLE; u_ack=0, u_dat_s=0, d_cyc=d_stb=d_we=0, d_sel=0, d_adr=0, d_dat_m=0.
- Reset mid-operation: any in-flight downstream cycle is abandoned (d_cyc drops asynchronously) and buffered writes are lost.
- Request valid: req = u_cyc & u_stb & ~u_ack. The ~u_ack term stops a held request from being accepted twice.
- Hit: u_adr equals the address of any valid entry.
- Storage: FIFO, head/tail pointers of width $clog2(DEPTH), wrapping modulo DEPTH. count is $clog2(DEPTH+1) bits. Full when count==DEPTH, empty when count==0.
- FSM states: IDLE, RD_FWD, DRAIN, RD_RESP.
- IDLE priority, highest first:
  1. req & ~u_we & ~hit -> RD_FWD.
  2. req & ~u_we & hit -> DRAIN the head entry.
  3. req & u_we & ~full -> enqueue {adr, sel, data} at tail and assert u_ack next cycle (write latency 1).
  4. count>0 and (no req, or req is a write and buffer is full) -> DRAIN.
  5. Otherwise stay in IDLE.
- Full buffer: a write is stalled (no u_ack) until a drain frees a slot.
- Writes are accepted only in IDLE.
- DRAIN: drive d_cyc=d_stb=d_we=1 with the head's adr/sel/data, held stable until d_ack. On d_ack: pop the head, count-1, go to IDLE.
- RD_FWD: drive d_cyc=d_stb=1, d_we=0, d_sel=16'hFFFF, d_adr=u_adr. On d_ack: latch d_dat_s into u_dat_s, go to RD_RESP.
- RD_RESP: u_ack=1 for exactly one cycle, then IDLE. Read latency is downstream latency + 1.
- d_rty in DRAIN or RD_FWD: drop d_stb (d_cyc stays high) for one cycle, then reissue the identical request. Retries are unbounded.
- Simultaneous events:
  - Upstream write arriving during DRAIN waits for IDLE.
  - Read hit on a non-head entry drains repeatedly, in order, until there is no hit, then forwards the read.
- u_ack is a single-cycle pulse in all cases.

Optional Feature:
- Macro: WB_WRITE_BUFFER_COALESCE_EN.
- Defined: a write in IDLE whose address hits a valid entry that is not the in-flight head merges into that entry. For each byte i, set sel[i] |= u_sel[i] and, if u_sel[i], overwrite data byte i. u_ack follows next cycle and count is unchanged. This is allowed even when full.
- Undefined: a matching write enqueues as a new entry; full stalls as normal.

Decomposition:
- Shared package lc3b_types gains:
  - typedefs lc3b_line_adr (12b), lc3b_line (128b), lc3b_line_sel (16b);
  - struct wb_buf_entry_t {valid, adr, sel, data}.
- One sub-module, wb_buffer_array, holds entry storage, head/tail/count, the parallel address-match vector (hit, hit index) and the byte-merge write port.
- The FSM and all port drivers stay in wb_write_buffer.

Test Plan:
- Write adr=12'h010 sel=FFFF data=A5..A5 into an empty buffer -> u_ack one cycle later; count=1; the drain later shows d_we=1, d_adr=010, d_dat_m=A5..A5.
- Five back-to-back writes adr 0x001..0x005 with DEPTH=4 and downstream ACK latency 3 -> first four acked at 1-cycle latency; the fifth's u_ack is withheld until the first drain d_ack, then asserted.
- Buffer holds adr 0x020, then a read of 0x020 -> the 0x020 write appears downstream before a read of 0x020; u_dat_s equals the downstream data; u_ack follows d_ack by 1 cycle.
- Read of 0x030 while 0x020 is buffered -> read forwarded first; 0x020 still buffered until the upstream side is idle.
- Downstream asserts d_rty on the first attempt of a drain -> d_stb low one cycle, identical request reissued, and the entry is popped only on d_ack.
- With the macro defined: writes to 0x040 with sel=000F data=..11 and then sel=00F0 data=..22 -> count=1 and one downstream write with sel=00FF carrying both bytes. Without the macro: count=2 and two writes in order.
- rst asserted during DRAIN -> d_cyc=0 immediately; count=0 and u_ack=0 after reset.
